// File: rtl/async_bus_initiator_if.sv
// Request/response handshake and bus pins of the async chip-select initiator.
// The bidirectional data lines are a plain port on the initiator itself.
interface async_bus_if #(
    parameter int ADDR_W = 9,
    parameter int DATA_W = 8
);
    logic              req;
    logic              wr;
    logic [ADDR_W-1:0] req_addr;
    logic [DATA_W-1:0] req_wdata;
    logic              ack;
    logic [DATA_W-1:0] rdata;
    logic              rvalid;
    logic              done;
    logic              busy;
    logic              nCS;
    logic              nOE;
    logic              nWE;
    logic [ADDR_W-1:0] addr;

    // Initiator side.
    modport master (
        input  req, wr, req_addr, req_wdata,
        output ack, rdata, rvalid, done, busy, nCS, nOE, nWE, addr
    );

    // Requester / responder side.
    modport slave (
        output req, wr, req_addr, req_wdata,
        input  ack, rdata, rvalid, done, busy, nCS, nOE, nWE, addr
    );
endinterface

// File: rtl/async_bus_initiator.sv
// Initiator for the 8-bit asynchronous chip-select bus. Issues one read or
// write per req/ack handshake with programmable setup/strobe/hold/turnaround.
// All outputs are registered, so pins trail the FSM state by one clock.
// Optional macro BUS_ARDY_EN adds ardy wait-state extension with a timeout.
module async_bus_initiator #(
    parameter int ADDR_W       = 9,
    parameter int DATA_W       = 8,
    parameter int SETUP_CYC    = 2,
    parameter int STROBE_CYC   = 4,
    parameter int HOLD_CYC     = 1,
    parameter int TURN_CYC     = 1,
    parameter int ARDY_TIMEOUT = 255
) (
    input  logic              clk,
    input  logic              nReset,
`ifdef BUS_ARDY_EN
    input  logic              ardy,
    output logic              timeout,
`endif
    inout  wire  [DATA_W-1:0] data,
    async_bus_if.master       bus
);
    // Zero or oversized loads would break the 4-bit down-counter.
    generate
        if (SETUP_CYC < 1 || SETUP_CYC > 15 || STROBE_CYC < 1 || STROBE_CYC > 15 ||
            HOLD_CYC < 1 || HOLD_CYC > 15 || TURN_CYC < 1 || TURN_CYC > 15 ||
            ARDY_TIMEOUT < 1) begin : g_bad_param
            $error("async_bus_initiator: timing parameters out of range");
        end
    endgenerate

    localparam logic [3:0] SETUP_LD  = 4'(SETUP_CYC);
    localparam logic [3:0] STROBE_LD = 4'(STROBE_CYC);
    localparam logic [3:0] HOLD_LD   = 4'(HOLD_CYC);
    localparam logic [3:0] TURN_LD   = 4'(TURN_CYC);

    typedef enum logic [2:0] {IDLE, SETUP, STROBE, HOLD, TURN} state_t;

    state_t            state, state_nx;
    logic [3:0]        cnt, cnt_nx;
    logic              wr_q;
    logic [ADDR_W-1:0] addr_lat;
    logic [DATA_W-1:0] wdata_lat;
    logic              active;
    logic              ack_d, rvalid_d, done_d, busy_d, ncs_d, noe_d, nwe_d, drv_d;
    logic [ADDR_W-1:0] addr_d;
    logic [DATA_W-1:0] rdata_d;
    logic              ack_q, rvalid_q, done_q, busy_q, ncs_q, noe_q, nwe_q, drv_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] rdata_q;
    logic              to_q;   // strobe ended by timeout; valid in first HOLD cycle

`ifdef BUS_ARDY_EN
    localparam int EXT_W = $clog2(ARDY_TIMEOUT + 1);
    logic [1:0]       ardy_sync;
    logic             ardy_s;
    logic [EXT_W-1:0] ext;
    logic             to_hit;
    logic             timeout_q;

    assign ardy_s = ardy_sync[1];
    // Still waiting after the full extension budget: give up this cycle.
    assign to_hit = (state == STROBE) && (cnt == 4'd1) && !ardy_s &&
                    (ext == EXT_W'(ARDY_TIMEOUT));

    // ardy synchronizer, extension counter and sticky timeout flag.
    always_ff @(posedge clk) begin
        if (!nReset) begin
            ardy_sync <= '0;
            ext       <= '0;
            to_q      <= 1'b0;
            timeout_q <= 1'b0;
        end else begin
            ardy_sync <= {ardy_sync[0], ardy};
            ext       <= (state == STROBE && state_nx == STROBE && cnt == 4'd1) ?
                         ext + 1'b1 : '0;
            to_q      <= to_hit;
            if (ack_d)       timeout_q <= 1'b0;
            else if (to_hit) timeout_q <= 1'b1;
        end
    end
    assign timeout = timeout_q;
`else
    assign to_q = 1'b0;
`endif

    // State register with the per-state down-counter.
    always_ff @(posedge clk) begin
        if (!nReset) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_nx;
            cnt   <= cnt_nx;
        end
    end

    // Next state: each state runs until its counter reaches 1, reloading on entry.
    always_comb begin
        state_nx = state;
        cnt_nx   = cnt - 4'd1;
        case (state)
            IDLE: begin
                cnt_nx = cnt;
                if (bus.req) begin
                    state_nx = SETUP;
                    cnt_nx   = SETUP_LD;
                end
            end
            SETUP: if (cnt == 4'd1) begin
                state_nx = STROBE;
                cnt_nx   = STROBE_LD;
            end
            STROBE: if (cnt == 4'd1) begin
`ifdef BUS_ARDY_EN
                if (ardy_s || to_hit) begin
                    state_nx = HOLD;
                    cnt_nx   = HOLD_LD;
                end else begin
                    cnt_nx = 4'd1;   // park on the last strobe cycle while extending
                end
`else
                state_nx = HOLD;
                cnt_nx   = HOLD_LD;
`endif
            end
            HOLD: if (cnt == 4'd1) begin
                state_nx = TURN;
                cnt_nx   = TURN_LD;
            end
            TURN: if (cnt == 4'd1) begin
                state_nx = IDLE;
                cnt_nx   = '0;
            end
            default: begin
                state_nx = IDLE;
                cnt_nx   = '0;
            end
        endcase
    end

    // Next values of the registered outputs, decoded from the current state.
    always_comb begin
        active   = (state == SETUP) || (state == STROBE) || (state == HOLD);
        ack_d    = (state == IDLE) && bus.req;
        busy_d   = (state != IDLE);
        ncs_d    = !active;
        noe_d    = !((state == STROBE) && !wr_q);
        nwe_d    = !((state == STROBE) && wr_q);
        drv_d    = active && wr_q;
        addr_d   = active ? addr_lat : addr_q;
        // First HOLD state cycle is the edge where the pin-level strobe ends.
        rvalid_d = (state == HOLD) && (cnt == HOLD_LD) && !wr_q;
        rdata_d  = rdata_q;
        if (rvalid_d) rdata_d = to_q ? '1 : data;
        done_d   = (state == TURN) && (cnt == 4'd1);
    end

    // Request capture on acceptance.
    always_ff @(posedge clk) begin
        if (!nReset) begin
            wr_q      <= 1'b0;
            addr_lat  <= '0;
            wdata_lat <= '0;
        end else if (ack_d) begin
            wr_q      <= bus.wr;
            addr_lat  <= bus.req_addr;
            wdata_lat <= bus.req_wdata;
        end
    end

    // Output registers; reset releases the bus on the same edge.
    always_ff @(posedge clk) begin
        if (!nReset) begin
            ack_q    <= 1'b0;
            rvalid_q <= 1'b0;
            done_q   <= 1'b0;
            busy_q   <= 1'b0;
            ncs_q    <= 1'b1;
            noe_q    <= 1'b1;
            nwe_q    <= 1'b1;
            drv_q    <= 1'b0;
            addr_q   <= '0;
            rdata_q  <= '0;
        end else begin
            ack_q    <= ack_d;
            rvalid_q <= rvalid_d;
            done_q   <= done_d;
            busy_q   <= busy_d;
            ncs_q    <= ncs_d;
            noe_q    <= noe_d;
            nwe_q    <= nwe_d;
            drv_q    <= drv_d;
            addr_q   <= addr_d;
            rdata_q  <= rdata_d;
        end
    end

    assign data       = drv_q ? wdata_lat : 'z;
    assign bus.ack    = ack_q;
    assign bus.rvalid = rvalid_q;
    assign bus.done   = done_q;
    assign bus.busy   = busy_q;
    assign bus.nCS    = ncs_q;
    assign bus.nOE    = noe_q;
    assign bus.nWE    = nwe_q;
    assign bus.addr   = addr_q;
    assign bus.rdata  = rdata_q;
endmodule

// File: tb/tb_async_bus_initiator.sv
// Bench for async_bus_initiator: default-timing instance plus a 1/1/1/1
// instance. Per-cycle pin activity is captured into bit masks indexed by
// cycle (cycle 0 = ack cycle); read data goes through a scoreboard queue.
module tb_async_bus_initiator;
    localparam int AW = 9;
    localparam int DW = 8;

    logic clk = 1'b0;
    logic nReset = 1'b0;
    always #5 clk = ~clk;

    async_bus_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();
    async_bus_if #(.ADDR_W(AW), .DATA_W(DW)) fbus ();
    wire [DW-1:0] data_bus;
    wire [DW-1:0] fdata;

    logic          keeper_en = 1'b1;
    logic          fkeep = 1'b1;
    logic [DW-1:0] resp_val = 8'h00;
    logic [DW-1:0] fresp_val = 8'h00;

    // Responder drives while nOE is low; the keeper holds 00 where the DUT must not drive.
    assign data_bus = !bus.nOE  ? resp_val  : (keeper_en ? 8'h00 : 'z);
    assign fdata    = !fbus.nOE ? fresp_val : (fkeep     ? 8'h00 : 'z);

    async_bus_initiator #(.ADDR_W(AW), .DATA_W(DW)) dut (
        .clk(clk), .nReset(nReset), .data(data_bus), .bus(bus.master));

    async_bus_initiator #(.ADDR_W(AW), .DATA_W(DW), .SETUP_CYC(1), .STROBE_CYC(1),
                          .HOLD_CYC(1), .TURN_CYC(1)) dut_fast (
        .clk(clk), .nReset(nReset), .data(fdata), .bus(fbus.master));

    int tests = 0;
    int fails = 0;
    logic [7:0] exp_q[$];

    // Monitor mux: sel=1 observes the fast instance.
    logic sel = 1'b0;
    wire [6:0]    mon_ctl   = sel ? {fbus.ack, fbus.rvalid, fbus.done, fbus.busy, fbus.nCS, fbus.nOE, fbus.nWE}
                                  : {bus.ack, bus.rvalid, bus.done, bus.busy, bus.nCS, bus.nOE, bus.nWE};
    wire [DW-1:0] mon_rdata = sel ? fbus.rdata : bus.rdata;
    wire [DW-1:0] mon_data  = sel ? fdata : data_bus;

    logic [31:0] m_ack, m_rv, m_done, m_busy, m_cs, m_oe, m_we, m_drv, m_bad;
    logic [7:0]  cap_rdata;
    logic        ack_seen;

    // Waits (bounded) for ack, then records ncyc cycles; drops req after nack acks.
    task automatic watch(input int ncyc, input int nack, input logic [7:0] wval, input logic [7:0] rval);
        int guard = 0;
        int acks = 0;
        {m_ack, m_rv, m_done, m_busy, m_cs, m_oe, m_we, m_drv, m_bad} = '0;
        cap_rdata = '0;
        @(negedge clk);
        while (mon_ctl[6] !== 1'b1 && guard < 40) begin
            @(negedge clk);
            guard++;
        end
        ack_seen = (mon_ctl[6] === 1'b1);
        for (int k = 0; k < ncyc; k++) begin
            if (k > 0) @(negedge clk);
            if (mon_ctl[6]) begin
                acks++;
                if (acks >= nack) begin bus.req = 1'b0; fbus.req = 1'b0; end
            end
            m_ack[k]  = mon_ctl[6];
            m_rv[k]   = mon_ctl[5];
            m_done[k] = mon_ctl[4];
            m_busy[k] = mon_ctl[3];
            m_cs[k]   = !mon_ctl[2];
            m_oe[k]   = !mon_ctl[1];
            m_we[k]   = !mon_ctl[0];
            m_drv[k]  = (mon_data === wval);
            m_bad[k]  = (mon_data !== (!mon_ctl[1] ? rval : 8'h00));
            if (mon_ctl[5]) cap_rdata = mon_rdata;
        end
    endtask

    task automatic test_reset();
        nReset = 1'b0;
        keeper_en = 1'b1;
        repeat (3) @(negedge clk);
        tests++; if ({bus.ack, bus.rvalid, bus.done, bus.busy, bus.nCS, bus.nOE, bus.nWE} !== 7'b0000111) begin
            fails++; $display("FAIL reset_ctl: got %b want %b", {bus.ack, bus.rvalid, bus.done, bus.busy, bus.nCS, bus.nOE, bus.nWE}, 7'b0000111); end
        tests++; if (bus.addr !== 9'h000) begin fails++; $display("FAIL reset_addr: got %h want 000", bus.addr); end
        tests++; if (bus.rdata !== 8'h00) begin fails++; $display("FAIL reset_rdata: got %h want 00", bus.rdata); end
        tests++; if (data_bus !== 8'h00) begin fails++; $display("FAIL reset_data_released: got %h want 00", data_bus); end
        tests++; if ({fbus.busy, fbus.nCS} !== 2'b01) begin fails++; $display("FAIL reset_fast: got %b want 01", {fbus.busy, fbus.nCS}); end
        nReset = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_write();
        sel = 1'b0; keeper_en = 1'b0;
        bus.wr = 1'b1; bus.req_addr = 9'h001; bus.req_wdata = 8'hA5; bus.req = 1'b1;
        watch(12, 1, 8'hA5, 8'h00);
        bus.req = 1'b0;
        tests++; if (!ack_seen) begin fails++; $display("FAIL write_ack_timeout: got no ack want ack"); end
        tests++; if (m_ack !== 32'h1) begin fails++; $display("FAIL write_ack: got %h want 1", m_ack); end
        tests++; if (m_cs !== 32'hFE) begin fails++; $display("FAIL write_ncs: got %h want fe", m_cs); end
        tests++; if (m_we !== 32'h78) begin fails++; $display("FAIL write_nwe: got %h want 78", m_we); end
        tests++; if (m_oe !== 32'h0) begin fails++; $display("FAIL write_noe: got %h want 0", m_oe); end
        tests++; if ((m_drv & 32'hFE) !== 32'hFE) begin fails++; $display("FAIL write_data: got %h want fe", m_drv & 32'hFE); end
        tests++; if (m_done !== 32'h100) begin fails++; $display("FAIL write_done: got %h want 100", m_done); end
        tests++; if (m_busy !== 32'h1FE) begin fails++; $display("FAIL write_busy: got %h want 1fe", m_busy); end
        tests++; if (bus.addr !== 9'h001) begin fails++; $display("FAIL write_addr: got %h want 001", bus.addr); end
    endtask

    task automatic test_read();
        logic [7:0] exp;
        sel = 1'b0; keeper_en = 1'b1; resp_val = 8'h74;
        bus.wr = 1'b0; bus.req_addr = 9'h00F; bus.req_wdata = 8'hC3;
        exp_q.push_back(8'h74);
        bus.req = 1'b1;
        watch(12, 1, 8'hC3, 8'h74);
        bus.req = 1'b0;
        tests++; if (m_oe !== 32'h78) begin fails++; $display("FAIL read_noe: got %h want 78", m_oe); end
        tests++; if (m_we !== 32'h0) begin fails++; $display("FAIL read_nwe: got %h want 0", m_we); end
        tests++; if (m_rv !== 32'h80) begin fails++; $display("FAIL read_rvalid: got %h want 80", m_rv); end
        tests++; if (m_bad !== 32'h0) begin fails++; $display("FAIL read_bus_driven: got %h want 0", m_bad); end
        tests++; if (m_done !== 32'h100) begin fails++; $display("FAIL read_done: got %h want 100", m_done); end
        exp = exp_q.pop_front();
        tests++; if (cap_rdata !== exp) begin fails++; $display("FAIL read_rdata: got %h want %h", cap_rdata, exp); end
        tests++; if (bus.addr !== 9'h00F) begin fails++; $display("FAIL read_addr: got %h want 00f", bus.addr); end
    endtask

    task automatic test_back_to_back();
        sel = 1'b0; keeper_en = 1'b0;
        bus.wr = 1'b1; bus.req_addr = 9'h155; bus.req_wdata = 8'h3C; bus.req = 1'b1;
        watch(22, 2, 8'h3C, 8'h00);
        bus.req = 1'b0;
        tests++; if (m_ack !== 32'h201) begin fails++; $display("FAIL b2b_ack: got %h want 201", m_ack); end
        tests++; if (m_done !== 32'h20100) begin fails++; $display("FAIL b2b_done: got %h want 20100", m_done); end
        tests++; if (m_cs !== 32'h1FCFE) begin fails++; $display("FAIL b2b_ncs: got %h want 1fcfe", m_cs); end
        tests++; if (bus.rdata !== 8'h74) begin fails++; $display("FAIL b2b_rdata_held: got %h want 74", bus.rdata); end
    endtask

    task automatic test_reset_mid();
        int guard = 0;
        int dones = 0;
        sel = 1'b0; keeper_en = 1'b0;
        bus.wr = 1'b1; bus.req_addr = 9'h0AA; bus.req_wdata = 8'h96; bus.req = 1'b1;
        @(negedge clk);
        while (bus.ack !== 1'b1 && guard < 40) begin @(negedge clk); guard++; end
        bus.req = 1'b0;
        while (bus.nWE !== 1'b0 && guard < 40) begin @(negedge clk); guard++; end
        tests++; if (bus.nWE !== 1'b0) begin fails++; $display("FAIL rmid_strobe_timeout: got nWE %b want 0", bus.nWE); end
        keeper_en = 1'b1;
        nReset = 1'b0;
        @(negedge clk);
        tests++; if ({bus.ack, bus.rvalid, bus.done, bus.busy, bus.nCS, bus.nOE, bus.nWE} !== 7'b0000111) begin
            fails++; $display("FAIL rmid_ctl: got %b want %b", {bus.ack, bus.rvalid, bus.done, bus.busy, bus.nCS, bus.nOE, bus.nWE}, 7'b0000111); end
        tests++; if (data_bus !== 8'h00) begin fails++; $display("FAIL rmid_data_released: got %h want 00", data_bus); end
        tests++; if (bus.rdata !== 8'h00) begin fails++; $display("FAIL rmid_rdata: got %h want 00", bus.rdata); end
        nReset = 1'b1;
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            if (bus.done) dones++;
        end
        tests++; if (dones != 0) begin fails++; $display("FAIL rmid_no_done: got %0d want 0", dones); end
    endtask

    task automatic test_fast();
        logic [7:0] exp;
        sel = 1'b1; fkeep = 1'b1; fresp_val = 8'h3C;
        fbus.wr = 1'b0; fbus.req_addr = 9'h123; fbus.req_wdata = 8'h81;
        exp_q.push_back(8'h3C);
        fbus.req = 1'b1;
        watch(8, 1, 8'h81, 8'h3C);
        fbus.req = 1'b0;
        tests++; if (m_oe !== 32'h4) begin fails++; $display("FAIL fast_noe: got %h want 4", m_oe); end
        tests++; if (m_cs !== 32'hE) begin fails++; $display("FAIL fast_ncs: got %h want e", m_cs); end
        tests++; if (m_rv !== 32'h8) begin fails++; $display("FAIL fast_rvalid: got %h want 8", m_rv); end
        tests++; if (m_done !== 32'h10) begin fails++; $display("FAIL fast_done: got %h want 10", m_done); end
        tests++; if (m_busy !== 32'h1E) begin fails++; $display("FAIL fast_busy: got %h want 1e", m_busy); end
        tests++; if (m_bad !== 32'h0) begin fails++; $display("FAIL fast_bus_driven: got %h want 0", m_bad); end
        exp = exp_q.pop_front();
        tests++; if (cap_rdata !== exp) begin fails++; $display("FAIL fast_rdata: got %h want %h", cap_rdata, exp); end
        sel = 1'b0;
    endtask

    initial begin
        bus.req = 1'b0;  bus.wr = 1'b0;  bus.req_addr = '0;  bus.req_wdata = '0;
        fbus.req = 1'b0; fbus.wr = 1'b0; fbus.req_addr = '0; fbus.req_wdata = '0;
        test_reset();
        test_write();
        test_read();
        test_back_to_back();
        test_reset_mid();
        test_fast();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end
endmodule

// File: doc/async_bus_initiator.md
Name: async_bus_initiator

Overview:
- Initiator for the 8-bit asynchronous chip-select bus used by the DSP-to-FPGA register interface. Drives nCS/nOE/nWE, addr and data toward an external 8-bit responder.
- Internal logic issues single read or write transactions through a req/ack handshake.
- Each strobe phase has programmable setup, strobe, hold and turnaround timing.
- Used for an FPGA-side master and as bench stimulus for register-file responders.

Parameters:
- ADDR_W, 9, bus address width
- DATA_W, 8, bus data width
- SETUP_CYC, 2, clk cycles with nCS low and address stable before the strobe; legal 1..15
- STROBE_CYC, 4, clk cycles nOE or nWE is held low; legal 1..15
- HOLD_CYC, 1, clk cycles nCS is held low after the strobe deasserts; legal 1..15
- TURN_CYC, 1, clk cycles nCS is high before the next transaction may start; legal 1..15
- ARDY_TIMEOUT, 255, maximum number of wait cycles (used only with BUS_ARDY_EN)

Ports:
- clk  in  1  system clock
- nReset  in  1  synchronous active-low reset
- req  in  1  transaction request; held high until ack
- wr  in  1  1 = write, 0 = read; sampled with req
- req_addr  in  ADDR_W  transaction address
- req_wdata  in  DATA_W  write data
- ack  out  1  one-cycle pulse; request accepted
- rdata  out  DATA_W  last read data; held until the next read
- rvalid  out  1  one-cycle pulse; rdata is updated
- done  out  1  one-cycle pulse; transaction is complete (end of TURN)
- busy  out  1  high in every state except IDLE
- nCS  out  1  chip select, active low
- nOE  out  1  output enable, active low
- nWE  out  1  write enable, active low
- addr  out  ADDR_W  bus address
- data  inout  DATA_W  bus data; driven only during a write transaction, otherwise high-Z

Behaviour:
- Reset: one clock with nReset=0 and the block returns to IDLE.
  - nCS, nOE, nWE = 1; ack, rvalid, done, busy = 0.
  - addr = 0; rdata = 0; data high-Z.
  - Reset mid-transaction aborts it with no done pulse, and the bus is released on that edge.
- All outputs are registered. There are no combinational paths from req to bus pins.
- FSM states: IDLE, SETUP, STROBE, HOLD, TURN. One 4-bit down-counter is reloaded on each state entry.
- IDLE:
  - When req=1, latch wr, req_addr and req_wdata, pulse ack, and go to SETUP.
  - req is ignored in every other state. A requester holding req after ack starts the next transaction only after TURN.
- SETUP, SETUP_CYC cycles:
  - nCS=0 and addr = latched address.
  - For a write, data is driven with the latched wdata from the first SETUP cycle.
- STROBE, STROBE_CYC cycles:
  - Write: nWE=0. Read: nOE=0.
  - The opposite strobe stays 1. nOE and nWE are never low simultaneously.
- Read capture: on the clk edge that ends the last STROBE cycle, data is captured into rdata and rvalid pulses in the first HOLD cycle.
- HOLD, HOLD_CYC cycles:
  - nCS=0 with both strobes high.
  - For a write, data and addr are held.
- TURN, TURN_CYC cycles:
  - nCS=1 and data is released to high-Z.
  - addr keeps its last value.
  - done pulses in the last TURN cycle, then the FSM returns to IDLE.
- busy=1 from the cycle after ack through the last TURN cycle.
- Default total time from the ack cycle to return to IDLE: 2+4+1+1 = 8 cycles. The next ack comes no earlier than cycle 9.
- A counter load value of 0 is illegal. Parameters outside 1..15 are flagged by a synthesis-time check.

Optional Feature:
- Macro: BUS_ARDY_EN.
- When defined:
  - Input port ardy (1 bit, synchronized through 2 flops inside the block) is added, plus output timeout (1 bit).
  - After STROBE_CYC cycles, STROBE extends while the synchronized ardy=0.
  - If the extension reaches ARDY_TIMEOUT cycles, the FSM goes to HOLD, read data = 8'hFF, and timeout stays high until the next ack.
  - When ardy=1 at the end of STROBE_CYC, there is no extension.
- When undefined: no ardy or timeout ports, and the strobe is fixed at STROBE_CYC.

Test Plan:
- Reset, then a write with req_addr=9'h001 and req_wdata=8'hA5 -> ack in cycle 0.
  - nCS low for cycles 1-7, nWE low for cycles 3-6, data=8'hA5 for cycles 1-7, done in cycle 8.
- A read from 9'h00F with the responder driving 8'h74 -> nOE low for 4 cycles, rdata=8'h74 with rvalid in the first HOLD cycle, data never driven.
- req held high for two writes in back-to-back order -> second ack arrives exactly one cycle after done, and nCS is high for at least TURN_CYC cycles between them.
- nReset=0 asserted during STROBE of a write -> the next edge shows nCS=nWE=1, data high-Z, busy=0, and no done pulse.
- Parameters SETUP_CYC=1, STROBE_CYC=1, HOLD_CYC=1, TURN_CYC=1 -> a read completes in 4 cycles after ack, and nOE is low for exactly 1 cycle.
- BUS_ARDY_EN defined:
  - ardy low for 10 cycles -> the strobe lasts 4+10+sync latency cycles, with timeout=0.
  - ardy held low -> after 255 extension cycles, timeout=1 and rdata=8'hFF.
